alu_req_master: RTL and testbench
=================================

ALU_REQ_MASTER -- requirements
Module: alu_req_master

Interface
REQ-001 Parameter CMDQ_DEPTH, default 4, command queue entries (power of 2, min 2).
REQ-002 Parameter MAX_OUTSTANDING, default 4, max issued-but-unanswered requests (power of 2, min 1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  host command present.
REQ-006 cmd_ready  out  1  command queue not full.
REQ-007 cmd_op  in  2  0=add, 1=sub, 2=mul, 3=div.
REQ-008 cmd_a  in  4  operand A.
REQ-009 cmd_b  in  4  operand B.
REQ-010 data  out  10  packed request {op[9:8], b[7:4], a[3:0]} to ALU pipeline.
REQ-011 valid  out  1  data holds a request.
REQ-012 ready  in  1  pipeline accepts data this cycle.
REQ-013 res_in  in  9  result word from pipeline.
REQ-014 res_valid  in  1  res_in valid.
REQ-015 res_ready  out  1  block accepts res_in.
REQ-016 rsp_valid  out  1  response to host present.
REQ-017 rsp_ready  in  1  host accepts response.
REQ-018 rsp_data  out  9  result returned to host.
REQ-019 rsp_op  out  2  opcode of the request this response answers.
REQ-020 rsp_err  out  1  response error flag (see Configuration).
REQ-021 stray_err  out  1  sticky: result arrived with nothing outstanding.

Function
REQ-022 Command accepted on cmd_valid && cmd_ready; stored in circular queue; cmd_ready = (queue count < CMDQ_DEPTH), no accept when full.
REQ-023 Issue FSM states IDLE, DRIVE: IDLE->DRIVE when queue non-empty and outstanding < MAX_OUTSTANDING; data/valid registered, first valid earliest one cycle after acceptance.
REQ-024 In DRIVE valid=1 and data stable until valid && ready; on transfer pop queue, push op into tag FIFO, outstanding+1.
REQ-025 After transfer, stay in DRIVE with next entry (back-to-back, no bubble) if queue non-empty and credit remains; else ->IDLE with valid=0.
REQ-026 res_ready = tag FIFO non-empty && (!rsp_valid || rsp_ready).
REQ-027 On res_valid && res_ready: pop tag FIFO, outstanding-1; next cycle rsp_valid=1, rsp_data=res_in, rsp_op=popped op; held stable until rsp_ready.
REQ-028 Responses returned strictly in issue order; no reordering.
REQ-029 Issue and retire in same cycle: outstanding unchanged; queue push and pop in same cycle: count unchanged, also when full.
REQ-030 Pointers wrap modulo depth; full/empty from occupancy counters, not pointer compare.
REQ-031 res_valid while tag FIFO empty: res_ready=0, word not consumed, stray_err set and held until reset.

Reset
REQ-032 Reset clears queue, tag FIFO, outstanding to 0; FSM=IDLE.
REQ-033 Outputs at reset: valid=0, data=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, stray_err=0, cmd_ready=1, res_ready=0.
REQ-034 Reset mid-transfer or mid-response discards all pending state; valid drops the cycle after reset is sampled.

Configuration
REQ-035 Macro ALU_DIV0_CHECK_EN defined: div with b=0 still issued (order kept), tag entry marks error, response has rsp_err=1, rsp_data=0 regardless of res_in.
REQ-036 Macro undefined: no error bit stored, rsp_err tied 0, rsp_data always res_in.

Verification
REQ-037 cmd op=0,a=3,b=5; ready=1 -> data=0x053 valid one cycle; res_in=8 -> rsp_valid, rsp_data=8, rsp_op=0.
REQ-038 5 commands, ready=1, no results -> exactly 4 issued then valid=0; one result -> 5th issued next cycle.
REQ-039 op=2,a=4,b=3 with ready=0 for 3 cycles -> valid=1, data=0x234 stable all 3 cycles, transfer on 4th.
REQ-040 ALU_DIV0_CHECK_EN: op=3,a=7,b=0 -> data=0x307 issued; res_in=0x1AA -> rsp_err=1, rsp_data=0.
REQ-041 res_valid=1 at idle after reset -> res_ready=0, stray_err=1 next cycle, stays 1.
REQ-042 Reset while valid=1 with 2 outstanding -> next cycle valid=0, cmd_ready=1, later result sets stray_err.

Source files
------------

// File: rtl/alu_req_master.sv
// Request master for the ALU pipeline: queues host commands, issues them with credit
// limiting, and returns results in order. Optional macro: ALU_DIV0_CHECK_EN.
module alu_req_master #(
  parameter int CMDQ_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [9:0] data,
  output logic       valid,
  input  logic       ready,
  input  logic [8:0] res_in,
  input  logic       res_valid,
  output logic       res_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic       stray_err
);

  localparam int QPW = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
  localparam int QCW = $clog2(CMDQ_DEPTH + 1);
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [QCW-1:0] QDEPTH = QCW'(CMDQ_DEPTH);
  localparam logic [TCW-1:0] TMAX   = TCW'(MAX_OUTSTANDING);
`ifdef ALU_DIV0_CHECK_EN
  localparam int TW = 3;
`else
  localparam int TW = 2;
`endif

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [9:0]      data_q, data_d;
  logic [9:0]      cmdq_mem [CMDQ_DEPTH];
  logic [QPW-1:0]  q_wr_q, q_rd_q;
  logic [QCW-1:0]  q_cnt_q, q_cnt_d;
  logic [TW-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [TPW-1:0]  t_wr_q, t_rd_q;
  logic [TCW-1:0]  out_cnt_q, out_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [8:0]      rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_op_q, rsp_op_d;
  logic            stray_q;
  logic            push, xfer, retire, credit;
  logic [9:0]      cmd_word;
  logic [TW-1:0]   tag_word, tag_head;

  function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
    return (p == QPW'(CMDQ_DEPTH - 1)) ? '0 : p + QPW'(1);
  endfunction

  function automatic logic [TPW-1:0] t_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
  endfunction

  assign cmd_ready = (q_cnt_q < QDEPTH);
  assign valid     = (state_q == DRIVE);
  assign data      = data_q;
  assign push      = cmd_valid && cmd_ready;
  assign xfer      = valid && ready;
  assign res_ready = (out_cnt_q != '0) && (!rsp_valid_q || rsp_ready);
  assign retire    = res_valid && res_ready;
  assign q_cnt_d   = q_cnt_q + QCW'(push) - QCW'(xfer);
  assign out_cnt_d = out_cnt_q + TCW'(xfer) - TCW'(retire);
  // Credit is judged on next-cycle occupancy so a retire frees a slot immediately.
  assign credit    = (out_cnt_d < TMAX);
  assign cmd_word  = {cmd_op, cmd_b, cmd_a};
  assign tag_head  = tag_mem[t_rd_q];

`ifdef ALU_DIV0_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  assign tag_word = {(data_q[9:8] == 2'd3) && (data_q[7:4] == 4'd0), data_q[9:8]};
  assign rsp_err  = rsp_err_q;
`else
  assign tag_word = data_q[9:8];
  assign rsp_err  = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign stray_err = stray_q;

  // The driven entry stays in the queue until transferred; an empty queue with a
  // same-cycle push forwards the incoming command straight into the data register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if ((q_cnt_q != '0 || push) && credit) begin
          state_d = DRIVE;
          data_d  = (q_cnt_q != '0) ? cmdq_mem[q_rd_q] : cmd_word;
        end
      end
      DRIVE: begin
        if (xfer) begin
          if ((q_cnt_q > QCW'(1) || push) && credit) begin
            data_d = (q_cnt_q > QCW'(1)) ? cmdq_mem[q_inc(q_rd_q)] : cmd_word;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
`ifdef ALU_DIV0_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    if (retire) begin
      rsp_valid_d = 1'b1;
      rsp_op_d    = tag_head[1:0];
`ifdef ALU_DIV0_CHECK_EN
      rsp_err_d   = tag_head[2];
      rsp_data_d  = tag_head[2] ? 9'd0 : res_in;
`else
      rsp_data_d  = res_in;
`endif
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      q_cnt_q     <= '0;
      t_wr_q      <= '0;
      t_rd_q      <= '0;
      out_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      stray_q     <= 1'b0;
`ifdef ALU_DIV0_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      q_cnt_q     <= q_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
`ifdef ALU_DIV0_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
      if (push)   q_wr_q <= q_inc(q_wr_q);
      if (xfer)   q_rd_q <= q_inc(q_rd_q);
      if (xfer)   t_wr_q <= t_inc(t_wr_q);
      if (retire) t_rd_q <= t_inc(t_rd_q);
      if (res_valid && out_cnt_q == '0) stray_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; occupancy counters make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) cmdq_mem[q_wr_q] <= cmd_word;
    if (xfer) tag_mem[t_wr_q]  <= tag_word;
  end

endmodule

// File: tb/tb_alu_req_master.sv
// Self-checking bench for alu_req_master: directed vector table, hand-written
// corner sequences, and a randomized phase against an in-order scoreboard model.
module tb_alu_req_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [9:0] data;
  logic       valid, ready;
  logic [8:0] res_in;
  logic       res_valid, res_ready;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err, stray_err;

  int checks = 0;
  int errors = 0;

  alu_req_master #(.CMDQ_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .data(data), .valid(valid), .ready(ready),
    .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected handshake with empty model queue", name);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; ready = 1'b0; res_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; res_in = '0;
    repeat (2) next();
    reset = 1'b0;
  endtask

  // Reference response: results come back in issue order; a div-by-zero tag forces
  // an error response with zero data when the check is compiled in.
  function automatic logic [11:0] model_rsp(input logic [9:0] w, input logic [8:0] res);
    logic err;
`ifdef ALU_DIV0_CHECK_EN
    err = (w[9:8] == 2'd3) && (w[7:4] == 4'd0);
`else
    err = 1'b0;
`endif
    return {err, w[9:8], err ? 9'd0 : res};
  endfunction

  // Transfer counter used by directed sequences (compare against a snapshot).
  int xfer_cnt = 0;
  always @(negedge clk) if (valid === 1'b1 && ready === 1'b1) xfer_cnt <= xfer_cnt + 1;

  // Scoreboard monitor for the randomized phase.
  logic        mon_en = 1'b0;
  logic [9:0]  cmd_q[$];
  logic [9:0]  iss_q[$];
  logic [11:0] rsp_q[$];
  logic        stall_v = 1'b0, stall_r = 1'b0;
  logic [9:0]  held_data;
  logic [11:0] held_rsp;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_v) begin
        chk("hold_valid", 32'(valid), 1);
        chk("hold_data", 32'(data), 32'(held_data));
      end
      if (stall_r) begin
        chk("hold_rsp_valid", 32'(rsp_valid), 1);
        chk("hold_rsp", 32'({rsp_err, rsp_op, rsp_data}), 32'(held_rsp));
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(cmd_q.size() < 4));
      chk("res_ready", 32'(res_ready), 32'(iss_q.size() > 0 && (!rsp_valid || rsp_ready)));
      chk("outstanding_le_max", 32'(iss_q.size() <= 4), 1);
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail_now("rsp_order");
        else chk("rsp_order", 32'({rsp_err, rsp_op, rsp_data}), 32'(rsp_q.pop_front()));
      end
      if (res_valid && res_ready) begin
        if (iss_q.size() == 0) fail_now("retire");
        else rsp_q.push_back(model_rsp(iss_q.pop_front(), res_in));
      end
      if (valid && ready) begin
        if (cmd_q.size() == 0) fail_now("issue");
        else begin
          logic [9:0] w;
          w = cmd_q.pop_front();
          chk("issue_data", 32'(data), 32'(w));
          iss_q.push_back(w);
        end
      end
      if (cmd_valid && cmd_ready) cmd_q.push_back({cmd_op, cmd_b, cmd_a});
      stall_v   = valid && !ready;
      held_data = data;
      stall_r   = rsp_valid && !rsp_ready;
      held_rsp  = {rsp_err, rsp_op, rsp_data};
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [8:0] res;
    logic [9:0] exp_data;
    logic [8:0] exp_rsp;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base, pushed, ok;
    logic done;

    vecs[0] = '{2'd0, 4'h3, 4'h5, 9'h008, 10'h053, 9'h008, 1'b0};
    vecs[1] = '{2'd1, 4'hF, 4'h1, 9'h00E, 10'h11F, 9'h00E, 1'b0};
    vecs[2] = '{2'd2, 4'h4, 4'h3, 9'h00C, 10'h234, 9'h00C, 1'b0};
`ifdef ALU_DIV0_CHECK_EN
    vecs[3] = '{2'd3, 4'h7, 4'h0, 9'h1AA, 10'h307, 9'h000, 1'b1};
`else
    vecs[3] = '{2'd3, 4'h7, 4'h0, 9'h1AA, 10'h307, 9'h1AA, 1'b0};
`endif
    vecs[4] = '{2'd3, 4'h8, 4'h2, 9'h004, 10'h328, 9'h004, 1'b0};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_op", 32'(rsp_op), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_stray", 32'(stray_err), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_res_ready", 32'(res_ready), 0);
    next();

    // Single-command transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      ready = 1'b1; cmd_valid = 1'b1;
      cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      @(negedge clk);
      chk("vec_cmd_ready", 32'(cmd_ready), 1);
      next();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("vec_valid", 32'(valid), 1);
      chk("vec_data", 32'(data), 32'(vecs[i].exp_data));
      next();
      @(negedge clk);
      chk("vec_valid_drop", 32'(valid), 0);
      res_valid = 1'b1; res_in = vecs[i].res;
      #1;
      chk("vec_res_ready", 32'(res_ready), 1);
      next();
      res_valid = 1'b0;
      @(negedge clk);
      chk("vec_rsp_valid", 32'(rsp_valid), 1);
      chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp_rsp));
      chk("vec_rsp_op", 32'(rsp_op), 32'(vecs[i].op));
      chk("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].exp_err));
      $display("vec %0d op=%0d a=%0h b=%0h data=%03h rsp=%03h err=%0b",
               i, vecs[i].op, vecs[i].a, vecs[i].b, data, rsp_data, rsp_err);
      rsp_ready = 1'b1;
      next();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("vec_rsp_drop", 32'(rsp_valid), 0);
      next();
    end

    // Back-pressure: data held stable for three stalled cycles, transfer on the fourth
    do_reset();
    ready = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 4'h4; cmd_b = 4'h3;
    next();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(valid), 1);
      chk("stall_data", 32'(data), 32'h234);
      next();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("stall_xfer_data", 32'(data), 32'h234);
    next();
    @(negedge clk);
    chk("stall_after_xfer", 32'(valid), 0);
    next();

    // Credit limit: five commands, only four issue until one result returns
    do_reset();
    ready = 1'b1; pushed = 0; base = xfer_cnt;
    for (int c = 0; c < 40; c++) begin
      cmd_valid = (pushed < 5);
      cmd_op = 2'(pushed % 4); cmd_a = 4'(pushed + 1); cmd_b = 4'(pushed + 2);
      @(negedge clk);
      if (cmd_valid && cmd_ready) pushed++;
      next();
    end
    cmd_valid = 1'b0;
    chk("credit_pushed", 32'(pushed), 5);
    chk("credit_issued", 32'(xfer_cnt - base), 4);
    @(negedge clk);
    chk("credit_valid_low", 32'(valid), 0);
    res_valid = 1'b1; res_in = 9'h001;
    #1;
    chk("credit_res_ready", 32'(res_ready), 1);
    next();
    res_valid = 1'b0;
    @(negedge clk);
    chk("credit_fifth_valid", 32'(valid), 1);
    chk("credit_fifth_data", 32'(data), 32'h065);
    next();

    // Stray result at idle
    do_reset();
    res_valid = 1'b1; res_in = 9'h055;
    @(negedge clk);
    chk("stray_res_ready", 32'(res_ready), 0);
    chk("stray_before", 32'(stray_err), 0);
    next();
    @(negedge clk);
    chk("stray_set", 32'(stray_err), 1);
    next();
    res_valid = 1'b0;
    repeat (3) next();
    @(negedge clk);
    chk("stray_sticky", 32'(stray_err), 1);
    next();

    // Reset while driving with two outstanding
    do_reset();
    ready = 1'b1; base = xfer_cnt;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        ok = 0;
        for (int i = 0; i < 20; i++) begin
          if (xfer_cnt - base >= 2) begin ok = 1; break; end
          next();
        end
        chk("rst_mid_two_issued", 32'(ok), 1);
        ready = 1'b0;
      end
      cmd_valid = 1'b1; cmd_op = 2'(k); cmd_a = 4'(k + 1); cmd_b = 4'(k + 1);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cmd_ready) begin ok = 1; break; end
        next();
      end
      chk("rst_mid_push", 32'(ok), 1);
      next();
      cmd_valid = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin ok = 1; break; end
      next();
    end
    chk("rst_mid_valid", 32'(ok), 1);
    chk("rst_mid_data", 32'(data), 32'h233);
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_drop", 32'(valid), 0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_mid_res_ready", 32'(res_ready), 0);
    res_valid = 1'b1; res_in = 9'h003;
    next();
    res_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_stray", 32'(stray_err), 1);
    next();

    // Randomized traffic against the scoreboard
    do_reset();
    cmd_q.delete(); iss_q.delete(); rsp_q.delete();
    stall_v = 1'b0; stall_r = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      ready     = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      res_valid = (iss_q.size() > 0) && ($urandom_range(0, 2) != 0);
      res_in    = 9'($urandom);
      next();
    end
    cmd_valid = 1'b0; ready = 1'b1; rsp_ready = 1'b1;
    done = 1'b0;
    for (int d = 0; d < 400; d++) begin
      if (cmd_q.size() == 0 && iss_q.size() == 0 && rsp_q.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
      res_valid = (iss_q.size() > 0);
      res_in    = 9'($urandom);
      next();
    end
    res_valid = 1'b0;
    chk("drain_complete", 32'(done), 1);
    @(negedge clk);
    chk("rand_no_stray", 32'(stray_err), 0);
    chk("rand_idle_valid", 32'(valid), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
